// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV flag register, condition evaluation and write-enable gating.
// Optional performance counters (ExecCnt/SkipCnt) are built only when COND_PERF_CNT_EN is defined.
module condlogic
`ifdef COND_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
`endif
);

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       condex;
  logic       condexr;
  logic [1:0] flag_write;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves condex unassigned and infers a latch.
    condex = 1'b1;
    case (cond_e'(Cond))
      EQ: condex = z;
      NE: condex = ~z;
      CS: condex = c;
      CC: condex = ~c;
      MI: condex = n;
      PL: condex = ~n;
      VS: condex = v;
      VC: condex = ~v;
      HI: condex = c & ~z;
      LS: condex = ~c | z;
      GE: condex = (n == v);
      LT: condex = (n != v);
      GT: condex = ~z & (n == v);
      LE: condex = z | (n != v);
      default: condex = 1'b1;
    endcase
  end

  assign flag_write = FlagW & {2{condex}};

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // reset is asynchronous, so the gated strobes drop the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      condexr <= 1'b0;
    end else begin
      condexr <= condex;
      if (flag_write[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_write[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Later FSM states use the registered condition so a mid-instruction flag write cannot change it.
  assign PCWrite  = (PCS & condexr) | NextPC;
  assign RegWrite = RegW & condexr;
  assign MemWrite = MemW & condexr;
  assign Flags    = flags_q;

`ifdef COND_PERF_CNT_EN
  logic             retire_valid;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] skip_q;

  // Each fetch retires the previous instruction; the first fetch after reset has nothing to retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_valid <= 1'b0;
      exec_q       <= '0;
      skip_q       <= '0;
    end else if (IRWrite) begin
      retire_valid <= 1'b1;
      if (retire_valid) begin
        if (condexr) exec_q <= exec_q + 1'b1;
        else         skip_q <= skip_q + 1'b1;
      end
    end
  end

  assign ExecCnt = exec_q;
  assign SkipCnt = skip_q;
`else
  wire unused_irwrite = IRWrite;
`endif

endmodule

// File: tb/tb_condlogic.sv
// Scoreboard bench for condlogic: a driver pushes expected outputs from a reference model,
// a negedge monitor pops and compares. Counter checks are compiled in with COND_PERF_CNT_EN.
module tb_condlogic;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, NextPC, RegW, MemW, IRWrite;
  logic             PCWrite, RegWrite, MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt, SkipCnt;

`ifdef COND_PERF_CNT_EN
  condlogic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .ExecCnt(ExecCnt), .SkipCnt(SkipCnt)
  );
`else
  condlogic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
  );
  assign ExecCnt = '0;
  assign SkipCnt = '0;
`endif

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_GE = 4'hA, C_LT = 4'hB,
                         C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE;

  typedef struct {
    bit       pcw, rw, mw;
    bit [3:0] flags;
    int       exec_cnt, skip_cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  bit [3:0] m_flags;
  bit       m_cx_r;
  bit       m_retire;
  int       m_exec, m_skip;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input bit [3:0] cc, input bit [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    m_flags  = 4'b0000;
    m_cx_r   = 1'b0;
    m_retire = 1'b0;
    m_exec   = 0;
    m_skip   = 0;
  endfunction

  // One clock cycle of stimulus: drive, push the expected response, advance the model to the next edge.
  task automatic step(input bit rst, input bit [3:0] cc, input bit [3:0] alu, input bit [1:0] fw,
                      input bit pcs, input bit npc, input bit rw, input bit mw, input bit irw);
    exp_t e;
    bit   cx;
    @(posedge clk);
    #1;
    reset = rst; Cond = cc; ALUFlags = alu; FlagW = fw;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw; IRWrite = irw;
    if (!rst) model_reset();
    e.pcw      = (pcs && m_cx_r) || npc;
    e.rw       = rw && m_cx_r;
    e.mw       = mw && m_cx_r;
    e.flags    = m_flags;
    e.exec_cnt = m_exec;
    e.skip_cnt = m_skip;
    q.push_back(e);
    if (rst) begin
      cx = cond_holds(cc, m_flags);
      if (irw) begin
        if (m_retire) begin
          if (m_cx_r) m_exec = (m_exec + 1) % (1 << CNT_W);
          else        m_skip = (m_skip + 1) % (1 << CNT_W);
        end
        m_retire = 1'b1;
      end
      m_cx_r = cx;
      if (fw[1] && cx) m_flags[3:2] = alu[3:2];
      if (fw[0] && cx) m_flags[1:0] = alu[1:0];
    end
  endtask

  // Three-cycle instruction: fetch with the new condition, then two cycles requesting writes.
  task automatic instr(input bit [3:0] cc);
    step(1, cc, 4'h0, 2'b00, 0, 1, 0, 0, 1);
    step(1, cc, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    step(1, cc, 4'h0, 2'b00, 1, 0, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("PCWrite",  {31'b0, PCWrite},  {31'b0, e.pcw});
      check("RegWrite", {31'b0, RegWrite}, {31'b0, e.rw});
      check("MemWrite", {31'b0, MemWrite}, {31'b0, e.mw});
      check("Flags",    {28'b0, Flags},    {28'b0, e.flags});
`ifdef COND_PERF_CNT_EN
      check("ExecCnt",  32'(ExecCnt), 32'(e.exec_cnt));
      check("SkipCnt",  32'(SkipCnt), 32'(e.skip_cnt));
`endif
    end
  end

  initial begin
    reset = 1'b0; Cond = '0; ALUFlags = '0; FlagW = '0;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0; IRWrite = 0;
    model_reset();
    step(0, C_AL, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(1, C_AL, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(1, C_AL, 4'hF, 2'b11, 0, 0, 0, 0, 0);
    step(1, C_AL, 4'h0, 2'b00, 1, 0, 1, 1, 0);

    // Asynchronous reset mid-cycle with all raw enables high
    @(posedge clk);
    #1;
    PCS = 1; RegW = 1; MemW = 1; NextPC = 0; FlagW = 2'b00;
    #1;
    check("pre-reset RegWrite", {31'b0, RegWrite}, 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check("async PCWrite",  {31'b0, PCWrite},  32'd0);
    check("async RegWrite", {31'b0, RegWrite}, 32'd0);
    check("async MemWrite", {31'b0, MemWrite}, 32'd0);
    check("async Flags",    {28'b0, Flags},    32'd0);
    step(0, C_AL, 4'h0, 2'b00, 0, 1, 1, 1, 0);

    // Set Z via AL, then EQ executes one cycle later
    step(1, C_AL, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
    step(1, C_EQ, 4'h0,    2'b00, 0, 0, 1, 0, 0);
    step(1, C_EQ, 4'h0,    2'b00, 0, 0, 1, 0, 0);
    #1 check("EQ taken Flags", {28'b0, Flags}, 32'h4);
    check("EQ taken RegWrite", {31'b0, RegWrite}, 32'd1);

    // NE fails: gated writes low and flag write annulled
    step(1, C_NE, 4'b1011, 2'b11, 1, 0, 1, 1, 0);
    step(1, C_NE, 4'b1011, 2'b11, 1, 0, 1, 1, 0);
    #1 check("NE annulled RegWrite", {31'b0, RegWrite}, 32'd0);
    check("NE annulled Flags", {28'b0, Flags}, 32'h4);

    // GE/LT with N=V=1, then GT/LE with N=1,V=0
    step(1, C_AL, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
    step(1, C_GE, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    step(1, C_LT, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    #1 check("GE N=V RegWrite", {31'b0, RegWrite}, 32'd1);
    step(1, C_AL, 4'b1000, 2'b11, 0, 0, 1, 0, 0);
    #1 check("LT N=V RegWrite", {31'b0, RegWrite}, 32'd0);
    step(1, C_GT, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    step(1, C_LE, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    #1 check("GT N!=V RegWrite", {31'b0, RegWrite}, 32'd0);
    step(1, C_AL, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    #1 check("LE N!=V RegWrite", {31'b0, RegWrite}, 32'd1);

    // Independent C,V half update from cleared flags
    step(0, C_AL, 4'h0,    2'b00, 0, 0, 0, 0, 0);
    step(1, C_AL, 4'b1111, 2'b01, 0, 0, 0, 0, 0);
    step(1, C_AL, 4'h0,    2'b00, 0, 0, 0, 0, 0);
    #1 check("CV-only Flags", {28'b0, Flags}, 32'h3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

`ifdef COND_PERF_CNT_EN
    // Counter scenario: 3 executed AL, 2 annulled EQ (Z=0 after reset)
    step(0, C_AL, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    instr(C_AL); instr(C_AL); instr(C_EQ); instr(C_AL); instr(C_EQ);
    instr(C_AL);
    #1 check("ExecCnt after 6th fetch", 32'(ExecCnt), 32'd3);
    check("SkipCnt after 6th fetch", 32'(SkipCnt), 32'd2);
    for (int i = 0; i < 13; i++) instr(C_AL);
    #1 check("ExecCnt wrap", 32'(ExecCnt), 32'd0);
    check("SkipCnt after wrap", 32'(SkipCnt), 32'd2);
`endif

    @(posedge clk);
    @(posedge clk);
    check("scoreboard drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
